ula_exec_ctrl: RTL and testbench
================================

Name: ula_exec_ctrl

Overview:
- Multi-cycle execute-stage controller directly upstream of the 16-bit ALU (op_select encoding: 0 add, 1 sub, 2 nand, 3 no_op with high-Z output).
- Accepts one instruction per valid/ready handshake and holds it in an internal instruction register.
- Owns an 8x16 register bank. Sequences operand reads, drives the ALU operands and op_select, captures the ALU result, and writes it back.
- Maintains zero/negative flags and reports completion or illegal opcodes.

Parameters:
- DATA_W, 16, datapath width; must equal the ALU width.
- NREGS, 8, register count; the address width is log2(NREGS), which is 3.
- RF_RESET, 16'h0000, reset value of every register.

Ports:
- clock  in  1  single system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  controller can accept an instruction.
- instr  in  16  [15:13] op, [12:10] rx, [9:7] ry, [9:0] imm10 (MVI only).
- ula_a  out  16  ALU operand A.
- ula_b  out  16  ALU operand B.
- ula_op  out  2  ALU op_select.
- ula_r  in  16  ALU result.
- done  out  1  one-cycle pulse on writeback.
- err  out  1  one-cycle pulse on illegal opcode.
- flag_z  out  1  last written result == 0.
- flag_n  out  1  bit 15 of the last written result.
- dbg_addr  in  3  debug read address.
- dbg_data  out  16  combinational read of rf[dbg_addr].

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State goes to IDLE and all registers are set to RF_RESET.
  - ula_a = ula_b = 0 and ula_op = 2'd3.
  - done = err = flag_z = flag_n = 0; instr_ready = 1.
  - Reset mid-operation abandons the instruction with no writeback.
- Opcodes:
  - 000 ADD: rx <- rx + ry.
  - 001 SUB: rx <- rx - ry.
  - 010 NAND: rx <- ~(rx & ry).
  - 011 MV: rx <- ry.
  - 100 MVI: rx <- sign-extend(imm10).
  - 101..111 are illegal.
- Arithmetic is modulo 2^16. There is no carry or overflow output.
- States: IDLE, RD_A, RD_B, EXEC, WB.
  - IDLE: instr_ready = 1. On instr_valid & instr_ready, latch instr into IR.
    - Legal op goes to RD_A.
    - Illegal op stays in IDLE and pulses err in the next cycle; nothing is written and flags are unchanged.
  - RD_A: ula_a <= rf[rx]. Go to RD_B.
  - RD_B: ula_b <= rf[ry] (MVI: sign-extended imm10). Go to EXEC.
  - EXEC: ula_op = IR op[1:0] for ADD/SUB/NAND, otherwise 2'd3. Capture result G: ula_r for ALU ops, ula_b for MV/MVI. Go to WB.
  - WB: rf[rx] <= G at the end of the cycle, update flags from G, done = 1. Go to IDLE.
- ula_op is 2'd3 in every state except EXEC. ula_r is never sampled outside EXEC, because the ALU output is Z then.
- instr_ready is 0 in RD_A..WB. Input instr is ignored while not accepting.
- Latency: accept at cycle T gives done at T+4. The new register value is visible on dbg_data at T+5, and instr_ready is 1 again at T+5. Throughput is one instruction per 5 cycles.
- rx == ry is legal; both operands read the pre-instruction value.
- dbg_data shows the old value during the WB cycle.
- done and err are never asserted in the same cycle.

Decomposition:
- Package ula_exec_pkg holds:
  - opcode localparams OP_ADD..OP_MVI;
  - ALU select constants ULA_ADD=0, ULA_SUB=1, ULA_NAND=2, ULA_NOP=3;
  - the state encoding;
  - instruction field bit positions.
- Sub-module reg_bank_8x16 provides one write port, two combinational read ports (operand, debug), and asynchronous active-low reset to RF_RESET.
- The FSM, IR, G and flags stay in ula_exec_ctrl.
- The bench instantiates the real ALU connected to ula_a/ula_b/ula_op/ula_r.

Test Plan:
- Reset: hold resetn = 0 mid-instruction, release, then read all 8 registers via dbg -> every register 0000, ula_op = 3, instr_ready = 1, done = 0.
- MVI r1, -3 (imm10 = 0x3FD) -> done at T+4, rf[1] = FFFD, flag_n = 1, flag_z = 0.
- MVI r2, 5; ADD r1, r2 -> rf[1] = 0002. ula_op = 0 only in the EXEC cycle; ula_op = 3 elsewhere.
- SUB r3, r2 with r3 = 0, r2 = 5 -> rf[3] = FFFB (wrap-around). NAND r2, r2 -> FFFA. MV r4, r3 -> rf[4] = FFFB.
- SUB r2, r2 -> rf[2] = 0000, flag_z = 1, flag_n = 0. Opcode 110 -> err pulse for one cycle, no register change, flags held, instr_ready stays 1.
- instr_valid held high with 3 back-to-back instructions -> accepts exactly every 5 cycles. instr changes while busy are ignored.

Source files
------------

// File: rtl/ula_exec_ctrl_pkg.sv
// Shared definitions for the ALU execute-stage controller: opcodes, ALU selects,
// FSM state encoding and instruction field positions.
package ula_exec_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_MV   = 3'b011;
  localparam logic [2:0] OP_MVI  = 3'b100;

  localparam logic [1:0] ULA_ADD  = 2'd0;
  localparam logic [1:0] ULA_SUB  = 2'd1;
  localparam logic [1:0] ULA_NAND = 2'd2;
  localparam logic [1:0] ULA_NOP  = 2'd3;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 13;
  localparam int RX_HI  = 12;
  localparam int RX_LO  = 10;
  localparam int RY_HI  = 9;
  localparam int RY_LO  = 7;
  localparam int IMM_HI = 9;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_t;

  function automatic logic is_legal(input logic [2:0] op);
    return (op <= OP_MVI);
  endfunction

  // Only these three opcodes actually use the ALU; MV/MVI bypass it.
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NAND);
  endfunction

  function automatic logic [15:0] sext_imm10(input logic [9:0] imm);
    return {{6{imm[9]}}, imm};
  endfunction

endpackage

// File: rtl/ula_exec_ctrl_if.sv
// Instruction handshake, ALU operand/result bus, status and debug read port.
interface ula_exec_ctrl_if #(
  parameter int DATA_W = 16
);

  logic              instr_valid;
  logic              instr_ready;
  logic [15:0]       instr;
  logic [DATA_W-1:0] ula_a;
  logic [DATA_W-1:0] ula_b;
  logic [1:0]        ula_op;
  logic [DATA_W-1:0] ula_r;
  logic              done;
  logic              err;
  logic              flag_z;
  logic              flag_n;
  logic [2:0]        dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output instr_valid, instr, ula_r, dbg_addr,
    input  instr_ready, ula_a, ula_b, ula_op, done, err, flag_z, flag_n, dbg_data
  );

  modport slave (
    input  instr_valid, instr, ula_r, dbg_addr,
    output instr_ready, ula_a, ula_b, ula_op, done, err, flag_z, flag_n, dbg_data
  );

endinterface

// File: rtl/ula_exec_ctrl_reg_bank.sv
// 8x16 register bank: one synchronous write port, combinational operand and
// debug read ports, asynchronous active-low reset of every entry.
module reg_bank_8x16 #(
  parameter int              DATA_W   = 16,
  parameter int              NREGS    = 8,
  parameter logic [DATA_W-1:0] RF_RESET = '0,
  localparam int             AW       = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] rf [NREGS];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREGS; i++) begin
        rf[i] <= RF_RESET;
      end
    end else if (we) begin
      rf[waddr] <= wdata;
    end
  end

  assign rdata    = rf[raddr];
  assign dbg_data = rf[dbg_addr];

endmodule

// File: rtl/ula_exec_ctrl.sv
// Multi-cycle execute controller: accepts one instruction, reads operands,
// drives the external ALU, captures the result and writes it back.
module ula_exec_ctrl
  import ula_exec_pkg::*;
#(
  parameter int              DATA_W   = 16,
  parameter int              NREGS    = 8,
  parameter logic [DATA_W-1:0] RF_RESET = '0
) (
  input  logic           clock,
  input  logic           resetn,
  ula_exec_ctrl_if.slave bus
);

  localparam int AW = $clog2(NREGS);

  state_t            state, state_next;
  logic [15:0]       ir;
  logic [DATA_W-1:0] ula_a_q, ula_b_q, g;
  logic              flag_z_q, flag_n_q, err_q;

  logic              ready_w, done_w, rf_we, accept;
  logic [1:0]        op_sel;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;

  logic [2:0]        ir_op;
  logic [AW-1:0]     ir_rx, ir_ry;
  logic [9:0]        ir_imm;

  assign ir_op  = ir[OP_HI:OP_LO];
  assign ir_rx  = ir[RX_HI:RX_LO];
  assign ir_ry  = ir[RY_HI:RY_LO];
  assign ir_imm = ir[IMM_HI:IMM_LO];

  assign accept = (state == S_IDLE) && bus.instr_valid;

  reg_bank_8x16 #(
    .DATA_W   (DATA_W),
    .NREGS    (NREGS),
    .RF_RESET (RF_RESET)
  ) u_rf (
    .clock    (clock),
    .resetn   (resetn),
    .we       (rf_we),
    .waddr    (ir_rx),
    .wdata    (g),
    .raddr    (rd_addr),
    .rdata    (rd_data),
    .dbg_addr (bus.dbg_addr),
    .dbg_data (bus.dbg_data)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Illegal opcodes are consumed in IDLE without leaving it; err follows a cycle later.
  always_comb begin
    state_next = state;
    ready_w    = 1'b0;
    op_sel     = ULA_NOP;
    done_w     = 1'b0;
    rf_we      = 1'b0;
    rd_addr    = ir_rx;
    unique case (state)
      S_IDLE: begin
        ready_w = 1'b1;
        if (bus.instr_valid && is_legal(bus.instr[OP_HI:OP_LO])) begin
          state_next = S_RD_A;
        end
      end
      S_RD_A: begin
        state_next = S_RD_B;
      end
      S_RD_B: begin
        rd_addr    = ir_ry;
        state_next = S_EXEC;
      end
      S_EXEC: begin
        if (is_alu_op(ir_op)) begin
          op_sel = ir_op[1:0];
        end
        state_next = S_WB;
      end
      S_WB: begin
        rf_we      = 1'b1;
        done_w     = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ula_r is only sampled in EXEC, where the ALU is actually driving it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ir       <= '0;
      ula_a_q  <= '0;
      ula_b_q  <= '0;
      g        <= '0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= accept && !is_legal(bus.instr[OP_HI:OP_LO]);
      if (accept) begin
        ir <= bus.instr;
      end
      if (state == S_RD_A) begin
        ula_a_q <= rd_data;
      end
      if (state == S_RD_B) begin
        ula_b_q <= (ir_op == OP_MVI) ? sext_imm10(ir_imm) : rd_data;
      end
      if (state == S_EXEC) begin
        g <= is_alu_op(ir_op) ? bus.ula_r : ula_b_q;
      end
      if (state == S_WB) begin
        flag_z_q <= (g == '0);
        flag_n_q <= g[DATA_W-1];
      end
    end
  end

  assign bus.instr_ready = ready_w;
  assign bus.ula_a       = ula_a_q;
  assign bus.ula_b       = ula_b_q;
  assign bus.ula_op      = op_sel;
  assign bus.done        = done_w;
  assign bus.err         = err_q;
  assign bus.flag_z      = flag_z_q;
  assign bus.flag_n      = flag_n_q;

endmodule

// File: tb/tb_ula_exec_ctrl.sv
// Self-checking bench for ula_exec_ctrl: cycle-level reference model plus
// directed instruction sequences with hand-computed register values.
module tb_ula_exec_ctrl;
  import ula_exec_pkg::*;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ula_exec_ctrl_if bus ();

  ula_exec_ctrl dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  // Behavioural 16-bit ALU; output floats on no_op.
  assign bus.ula_r = (bus.ula_op == 2'd0) ? bus.ula_a + bus.ula_b :
                     (bus.ula_op == 2'd1) ? bus.ula_a - bus.ula_b :
                     (bus.ula_op == 2'd2) ? ~(bus.ula_a & bus.ula_b) : 16'hzzzz;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles elapsed since acceptance, result computed at acceptance.
  int          m_cnt;
  logic [15:0] m_rf [8];
  logic        m_z, m_n, m_err;
  logic [2:0]  m_op, m_rx;
  logic [15:0] m_a, m_b, m_res;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_cnt = 0;
      for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
      m_z = 1'b0; m_n = 1'b0; m_err = 1'b0; m_op = 3'd0;
    end else begin
      m_err = 1'b0;
      if (m_cnt == 4) begin
        m_rf[m_rx] = m_res;
        m_z = (m_res == 16'h0000);
        m_n = m_res[15];
        m_cnt = 0;
      end else if (m_cnt > 0) begin
        m_cnt++;
      end else if (bus.instr_valid) begin
        if (bus.instr[15:13] > 3'd4) begin
          m_err = 1'b1;
        end else begin
          m_op = bus.instr[15:13];
          m_rx = bus.instr[12:10];
          m_a  = m_rf[bus.instr[12:10]];
          m_b  = (m_op == 3'd4) ? {{6{bus.instr[9]}}, bus.instr[9:0]} : m_rf[bus.instr[9:7]];
          case (m_op)
            3'd0:    m_res = m_a + m_b;
            3'd1:    m_res = m_a - m_b;
            3'd2:    m_res = ~(m_a & m_b);
            default: m_res = m_b;
          endcase
          m_cnt = 1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (resetn) begin
      checkOutput("instr_ready", 32'(bus.instr_ready), 32'(m_cnt == 0));
      checkOutput("done", 32'(bus.done), 32'(m_cnt == 4));
      checkOutput("err", 32'(bus.err), 32'(m_err));
      checkOutput("ula_op", 32'(bus.ula_op), (m_cnt == 3 && m_op <= 3'd2) ? 32'(m_op) : 32'd3);
      checkOutput("flag_z", 32'(bus.flag_z), 32'(m_z));
      checkOutput("flag_n", 32'(bus.flag_n), 32'(m_n));
      checkOutput("dbg_data", 32'(bus.dbg_data), 32'(m_rf[bus.dbg_addr]));
      if (m_cnt == 3) begin
        checkOutput("ula_a", 32'(bus.ula_a), 32'(m_a));
        checkOutput("ula_b", 32'(bus.ula_b), 32'(m_b));
      end
    end
  end

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry);
    return {op, rx, ry, 7'b0};
  endfunction

  function automatic logic [15:0] encImm(input logic [2:0] rx, input logic [9:0] imm);
    return {3'b100, rx, imm};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic readReg(input logic [2:0] a, input logic [15:0] exp);
    bus.dbg_addr = a;
    step();
    checkOutput($sformatf("rf[%0d]", a), 32'(bus.dbg_data), 32'(exp));
  endtask

  // Issues one instruction and returns in the cycle after done (T+5).
  task automatic applyStimulus(input logic [15:0] w);
    int n;
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    bus.instr       = 16'($urandom);
    n = 1;
    while (!bus.done && n < 8) begin
      step();
      n++;
    end
    checkOutput("latency", 32'(n), 32'd4);
    step();
    checkOutput("ready_after", 32'(bus.instr_ready), 32'd1);
  endtask

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int acc [3];
    int k, cyc;
    logic [15:0] prog [3];

    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
    bus.dbg_addr    = 3'd0;
    repeat (3) step();
    resetn = 1'b1;
    step();
    checkOutput("rst_ready", 32'(bus.instr_ready), 32'd1);
    checkOutput("rst_ula_op", 32'(bus.ula_op), 32'd3);
    checkOutput("rst_ula_a", 32'(bus.ula_a), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);

    applyStimulus(encImm(3'd5, 10'd7));
    readReg(3'd5, 16'h0007);

    // Abandon an in-flight MVI with reset.
    bus.instr = encImm(3'd6, 10'd9);
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    step();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
    step();
    checkOutput("rst2_ula_op", 32'(bus.ula_op), 32'd3);
    checkOutput("rst2_ready", 32'(bus.instr_ready), 32'd1);
    checkOutput("rst2_done", 32'(bus.done), 32'd0);
    for (int i = 0; i < 8; i++) readReg(3'(i), 16'h0000);

    applyStimulus(encImm(3'd1, 10'h3FD));
    readReg(3'd1, 16'hFFFD);
    checkOutput("mvi_flag_n", 32'(bus.flag_n), 32'd1);
    checkOutput("mvi_flag_z", 32'(bus.flag_z), 32'd0);

    applyStimulus(encImm(3'd2, 10'd5));
    applyStimulus(enc(3'b000, 3'd1, 3'd2));
    readReg(3'd1, 16'h0002);

    applyStimulus(enc(3'b001, 3'd3, 3'd2));
    readReg(3'd3, 16'hFFFB);
    applyStimulus(enc(3'b010, 3'd2, 3'd2));
    readReg(3'd2, 16'hFFFA);
    applyStimulus(enc(3'b011, 3'd4, 3'd3));
    readReg(3'd4, 16'hFFFB);

    applyStimulus(enc(3'b001, 3'd2, 3'd2));
    readReg(3'd2, 16'h0000);
    checkOutput("sub_flag_z", 32'(bus.flag_z), 32'd1);
    checkOutput("sub_flag_n", 32'(bus.flag_n), 32'd0);

    bus.instr = {3'b110, 13'h0ABC};
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    checkOutput("ill_err", 32'(bus.err), 32'd1);
    checkOutput("ill_ready", 32'(bus.instr_ready), 32'd1);
    step();
    checkOutput("ill_err_end", 32'(bus.err), 32'd0);
    checkOutput("ill_flag_z", 32'(bus.flag_z), 32'd1);
    readReg(3'd2, 16'h0000);
    readReg(3'd4, 16'hFFFB);

    // Back-to-back with instr_valid held high and junk on instr while busy.
    prog[0] = encImm(3'd7, 10'h1FF);
    prog[1] = enc(3'b000, 3'd7, 3'd7);
    prog[2] = enc(3'b011, 3'd0, 3'd7);
    k = 0;
    cyc = 0;
    bus.instr_valid = 1'b1;
    while (cyc < 40) begin
      if (bus.instr_ready) begin
        if (k == 3) break;
        bus.instr = prog[k];
        acc[k] = cyc;
        k++;
      end else begin
        bus.instr = 16'($urandom);
      end
      step();
      cyc++;
    end
    bus.instr_valid = 1'b0;
    checkOutput("b2b_count", 32'(k), 32'd3);
    checkOutput("b2b_gap1", 32'(acc[1] - acc[0]), 32'd5);
    checkOutput("b2b_gap2", 32'(acc[2] - acc[1]), 32'd5);
    readReg(3'd7, 16'h03FE);
    readReg(3'd0, 16'h03FE);
    readReg(3'd1, 16'h0002);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
